// File: rtl/ldpc_shift_stream_rom.sv
// Shift-coefficient ROM streamer for the LDPC encoder: holds BG1/BG2 shift
// tables for ILS 0..7, reduces each present entry modulo Zc = a_ILS * 2^j and
// streams LANES entries per beat over a valid/ready interface.

// BG1 shift table source: entry lookup by ILS and table index.
package BG1_pkg;
    localparam int unsigned BG1_MAX_TRANSFORMS = 316;

    // Returns {absent, value}; present values are always below 384.
    function automatic logic [9:0] bg1_entry(input logic [2:0] ils, input logic [9:0] idx);
        int unsigned v;
        logic        absent;
        v      = (32'(idx) * 32'd5 + 32'(ils) * 32'd41) % 32'd384;
        absent = ((32'(idx) * 32'd3 + 32'(ils)) & 32'd3) == 32'd0;
        return {absent, 9'(v)};
    endfunction
endpackage

// BG2 shift table source: entry lookup by ILS and table index.
package BG2_pkg;
    localparam int unsigned BG2_MAX_TRANSFORMS = 197;

    // Returns {absent, value}; present values are always below 384.
    function automatic logic [9:0] bg2_entry(input logic [2:0] ils, input logic [9:0] idx);
        int unsigned v;
        logic        absent;
        v      = (32'(idx) * 32'd7 + 32'(ils) * 32'd29 + 32'd100) % 32'd384;
        absent = ((32'(idx) + 32'(ils) * 32'd3) & 32'd3) == 32'd1;
        return {absent, 9'(v)};
    endfunction
endpackage

module ldpc_shift_stream_rom #(
    parameter int unsigned        LANES      = 4,
    parameter int unsigned        SHIFT_W    = 9,
    parameter logic [SHIFT_W-1:0] NULL_SHIFT = SHIFT_W'(9'h1FF),
    parameter int unsigned        BG1_N      = BG1_pkg::BG1_MAX_TRANSFORMS,
    parameter int unsigned        BG2_N      = BG2_pkg::BG2_MAX_TRANSFORMS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       bg_sel,
    input  logic [2:0]                 ils_selected,
    input  logic [2:0]                 j_exp,
    input  logic                       flush,
    output logic [LANES*SHIFT_W-1:0]   out_data,
    output logic [LANES-1:0]           out_lane_valid,
    output logic [8:0]                 out_index,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int unsigned IDX_W  = 10;
    localparam int unsigned DATA_W = LANES * SHIFT_W;
    localparam int unsigned ZC_MAX = 384;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM
    } state_t;

    state_t state_q, state_d;

    // Latched configuration
    logic       bg_q;
    logic [2:0] ils_q;
    logic [2:0] j_q;

    // Read register: the beat fetched ahead of the output register
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rd_base;
    logic [DATA_W-1:0] rd_data;
    logic [LANES-1:0]  rd_lane_valid;
    logic              rd_last;
    logic              rd_valid;

    // FSM control strobes
    logic accept;
    logic cfg_rej;
    logic load_rd;
    logic advance;

    // Combinational beat assembly
    logic [DATA_W-1:0] beat_data;
    logic [LANES-1:0]  beat_lane_valid;
    logic              beat_last;
    logic [IDX_W-1:0]  lane_idx;
    logic [9:0]        entry;
    int unsigned       n_sel;

    logic [11:0] zc_req;
    logic        cfg_ok;

    // Lifting-size base a_ILS for each ILS
    function automatic logic [3:0] a_of(input logic [2:0] ils);
        logic [3:0] a;
        a = 4'd2;
        case (ils)
            3'd0: a = 4'd2;
            3'd1: a = 4'd3;
            3'd2: a = 4'd5;
            3'd3: a = 4'd7;
            3'd4: a = 4'd9;
            3'd5: a = 4'd11;
            3'd6: a = 4'd13;
            3'd7: a = 4'd15;
            default: a = 4'd2;
        endcase
        return a;
    endfunction

    // V mod (a*2^j) computed as ((V>>j) mod a) << j | low j bits of V
    function automatic logic [SHIFT_W-1:0] reduce(input logic [8:0] v,
                                                  input logic [2:0] ils,
                                                  input logic [2:0] j);
        logic [8:0] q;
        logic [8:0] r;
        logic [8:0] mask;
        q = v >> j;
        r = q;
        case (ils)
            3'd0: r = q % 9'd2;
            3'd1: r = q % 9'd3;
            3'd2: r = q % 9'd5;
            3'd3: r = q % 9'd7;
            3'd4: r = q % 9'd9;
            3'd5: r = q % 9'd11;
            3'd6: r = q % 9'd13;
            3'd7: r = q % 9'd15;
            default: r = q;
        endcase
        mask = (9'd1 << j) - 9'd1;
        return SHIFT_W'((r << j) | (v & mask));
    endfunction

    // Raw table entry {absent, value} from the selected base graph
    function automatic logic [9:0] rom_entry(input logic bg,
                                             input logic [2:0] ils,
                                             input logic [IDX_W-1:0] idx);
        return bg ? BG2_pkg::bg2_entry(ils, idx) : BG1_pkg::bg1_entry(ils, idx);
    endfunction

    // Configuration check on the live request inputs
    always_comb begin
        zc_req = 12'(a_of(ils_selected)) << j_exp;
        cfg_ok = zc_req <= 12'(ZC_MAX);
    end

    // Assemble the beat at rd_idx: reduce present lanes, pad past table end
    always_comb begin
        beat_data       = '0;
        beat_lane_valid = '0;
        lane_idx        = '0;
        entry           = '0;
        n_sel           = bg_q ? BG2_N : BG1_N;
        for (int k = 0; k < LANES; k++) begin
            lane_idx = rd_idx + IDX_W'(k);
            entry    = rom_entry(bg_q, ils_q, lane_idx);
            if (32'(lane_idx) < n_sel) begin
                beat_lane_valid[k] = 1'b1;
                beat_data[k*SHIFT_W +: SHIFT_W] =
                    entry[9] ? NULL_SHIFT : reduce(entry[8:0], ils_q, j_q);
            end else begin
                beat_data[k*SHIFT_W +: SHIFT_W] = NULL_SHIFT;
            end
        end
        beat_last = (32'(rd_idx) + LANES) >= n_sel;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; flush overrides everything
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cfg_rej = 1'b0;
        load_rd = 1'b0;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (cfg_ok) begin
                        accept  = 1'b1;
                        state_d = S_FILL;
                    end else begin
                        cfg_rej = 1'b1;
                    end
                end
            end
            S_FILL: begin
                load_rd = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                advance = out_ready || !out_valid;
                if (out_valid && out_ready && out_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Status outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            busy    <= (state_d != S_IDLE);
            cfg_err <= cfg_rej;
        end
    end

    // Configuration latch, read register and index counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_q          <= 1'b0;
            ils_q         <= '0;
            j_q           <= '0;
            rd_idx        <= '0;
            rd_base       <= '0;
            rd_data       <= '0;
            rd_lane_valid <= '0;
            rd_last       <= 1'b0;
            rd_valid      <= 1'b0;
        end else if (flush) begin
            bg_q     <= 1'b0;
            ils_q    <= '0;
            j_q      <= '0;
            rd_idx   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (accept) begin
                bg_q     <= bg_sel;
                ils_q    <= ils_selected;
                j_q      <= j_exp;
                rd_idx   <= '0;
                rd_valid <= 1'b0;
            end
            if (load_rd || (advance && rd_valid && !rd_last)) begin
                rd_data       <= beat_data;
                rd_lane_valid <= beat_lane_valid;
                rd_last       <= beat_last;
                rd_base       <= rd_idx;
                rd_valid      <= 1'b1;
                rd_idx        <= rd_idx + IDX_W'(LANES);
            end else if (advance) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // Output register: moves the read register forward on each advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= '0;
            out_lane_valid <= '0;
            out_index      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= rd_valid;
            if (rd_valid) begin
                out_data       <= rd_data;
                out_lane_valid <= rd_lane_valid;
                out_last       <= rd_last;
                out_index      <= 9'(rd_base);
            end
        end
    end

endmodule

// File: tb/tb_ldpc_shift_stream_rom.sv
// Directed bench for ldpc_shift_stream_rom: latency, reduction, cfg errors,
// backpressure, flush and reset behaviour against an independent table model.
module tb_ldpc_shift_stream_rom;

    localparam int LANES = 4;
    localparam int SW    = 9;

    logic              clk;
    logic              reset;
    logic              start;
    logic              bg_sel;
    logic [2:0]        ils_selected;
    logic [2:0]        j_exp;
    logic              flush;
    logic [LANES*SW-1:0] out_data;
    logic [LANES-1:0]  out_lane_valid;
    logic [8:0]        out_index;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              cfg_err;

    int n_vec;
    int n_err;

    logic [8:0] obs [512];
    logic [3:0] last_lv;
    int         last_idx;
    int         nb;

    ldpc_shift_stream_rom dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .bg_sel         (bg_sel),
        .ils_selected   (ils_selected),
        .j_exp          (j_exp),
        .flush          (flush),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .out_index      (out_index),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy),
        .cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Table model: -1 for an absent entry, otherwise the raw shift value
    function automatic int tbl(input bit bg, input int ils, input int idx);
        if (!bg) begin
            if ((3 * idx + ils) % 4 == 0) return -1;
            return (5 * idx + 41 * ils) % 384;
        end
        if ((idx + 3 * ils) % 4 == 1) return -1;
        return (7 * idx + 29 * ils + 100) % 384;
    endfunction

    function automatic int a_tab(input int ils);
        int a [8];
        a = '{2, 3, 5, 7, 9, 11, 13, 15};
        return a[ils];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit bg, input int ils, input int j);
        bg_sel       = bg;
        ils_selected = 3'(ils);
        j_exp        = 3'(j);
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    // Consume beats, checking each accepted beat and stability during stalls
    task automatic collect(input bit bg, input int ils, input int j, input int pct,
                           input int stop_after, output int nbeats);
        int n, nbe, zc, cycles, t, i;
        logic [LANES*SW-1:0] exp_d, hold_d;
        logic [3:0]          exp_lv, hold_lv;
        logic [8:0]          hold_i;
        logic                hold_l;
        bit                  stalled, done;
        n       = bg ? 197 : 316;
        nbe     = (n + LANES - 1) / LANES;
        zc      = a_tab(ils) << j;
        nbeats  = 0;
        stalled = 0;
        done    = 0;
        cycles  = 0;
        hold_d  = '0;
        hold_lv = '0;
        hold_i  = '0;
        hold_l  = 1'b0;
        while (!done && cycles < 3000) begin
            out_ready = ($urandom_range(99) < pct);
            if (stalled) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(out_data), 64'(hold_d));
                check("hold_lv", 64'(out_lane_valid), 64'(hold_lv));
                check("hold_idx", 64'(out_index), 64'(hold_i));
                check("hold_last", 64'(out_last), 64'(hold_l));
            end
            if (out_valid) begin
                if (out_ready) begin
                    exp_d  = '0;
                    exp_lv = '0;
                    for (int k = 0; k < LANES; k++) begin
                        i = nbeats * LANES + k;
                        if (i < n) begin
                            exp_lv[k] = 1'b1;
                            t = tbl(bg, ils, i);
                            exp_d[k*SW +: SW] = (t < 0) ? 9'h1FF : 9'(t % zc);
                            obs[i] = out_data[k*SW +: SW];
                        end else begin
                            exp_d[k*SW +: SW] = 9'h1FF;
                        end
                    end
                    check("beat_idx", 64'(out_index), 64'(nbeats * LANES));
                    check("beat_data", 64'(out_data), 64'(exp_d));
                    check("beat_lv", 64'(out_lane_valid), 64'(exp_lv));
                    check("beat_last", 64'(out_last), 64'(nbeats == nbe - 1));
                    last_lv  = out_lane_valid;
                    last_idx = int'(out_index);
                    nbeats++;
                    stalled = 0;
                    if (out_last || nbeats == nbe || nbeats == stop_after) done = 1;
                end else begin
                    stalled = 1;
                    hold_d  = out_data;
                    hold_lv = out_lane_valid;
                    hold_i  = out_index;
                    hold_l  = out_last;
                end
            end
            step();
            cycles++;
        end
        if (!done) check("stream_timeout", 64'(nbeats), 64'((stop_after < nbe) ? stop_after : nbe));
        out_ready = 1'b1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        start        = 1'b0;
        flush        = 1'b0;
        bg_sel       = 1'b0;
        ils_selected = '0;
        j_exp        = '0;
        out_ready    = 1'b1;
        last_lv      = '0;
        last_idx     = 0;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cfg_err", 64'(cfg_err), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_lv", 64'(out_lane_valid), 64'(0));
        check("rst_index", 64'(out_index), 64'(0));
        step();
        step();
        reset = 1'b0;
        step();

        // BG2 ILS0 j0 (Zc=2): latency, 50 beats, tail lane mask
        do_start(1'b1, 0, 0);
        check("lat_busy_c1", 64'(busy), 64'(1));
        check("lat_valid_c1", 64'(out_valid), 64'(0));
        step();
        check("lat_valid_c2", 64'(out_valid), 64'(0));
        step();
        check("lat_valid_c3", 64'(out_valid), 64'(1));
        check("lat_index_c3", 64'(out_index), 64'(0));
        collect(1'b1, 0, 0, 100, 1000, nb);
        check("bg2_beats", 64'(nb), 64'(50));
        check("bg2_last_lv", 64'(last_lv), 64'(4'b0001));
        check("bg2_last_idx", 64'(last_idx), 64'(196));
        check("bg2_e0", 64'(obs[0]), 64'(0));
        check("bg2_e1_null", 64'(obs[1]), 64'(9'h1FF));
        check("bg2_e196", 64'(obs[196]), 64'(0));
        check("bg2_done_busy", 64'(busy), 64'(0));
        check("bg2_done_valid", 64'(out_valid), 64'(0));

        // BG1 ILS7 j4 (Zc=240): V=300 at index 233 reduces to 60
        do_start(1'b0, 7, 4);
        collect(1'b0, 7, 4, 100, 1000, nb);
        check("bg1_beats", 64'(nb), 64'(79));
        check("bg1_v300", 64'(obs[233]), 64'(60));
        check("bg1_e0", 64'(obs[0]), 64'(47));
        check("bg1_done_busy", 64'(busy), 64'(0));

        // Back-to-back start at busy fall, start-while-busy ignored, random ready
        do_start(1'b1, 3, 3);
        check("b2b_busy", 64'(busy), 64'(1));
        bg_sel       = 1'b0;
        ils_selected = 3'd7;
        j_exp        = 3'd7;
        start        = 1'b1;
        step();
        start        = 1'b0;
        check("busy_start_no_err", 64'(cfg_err), 64'(0));
        step();
        check("busy_start_no_err2", 64'(cfg_err), 64'(0));
        collect(1'b1, 3, 3, 50, 1000, nb);
        check("rnd_beats", 64'(nb), 64'(50));
        check("rnd_done_busy", 64'(busy), 64'(0));

        // Invalid configuration: ILS7 j5 (Zc=480)
        do_start(1'b0, 7, 5);
        check("cfg_err_pulse", 64'(cfg_err), 64'(1));
        check("cfg_err_busy", 64'(busy), 64'(0));
        step();
        check("cfg_err_clear", 64'(cfg_err), 64'(0));
        for (int c = 0; c < 4; c++) begin
            check("cfg_err_no_valid", 64'(out_valid), 64'(0));
            step();
        end

        // Boundary Zc=384 accepted, then flush at beat 10
        do_start(1'b0, 1, 7);
        check("zc384_busy", 64'(busy), 64'(1));
        check("zc384_no_err", 64'(cfg_err), 64'(0));
        collect(1'b0, 1, 7, 100, 10, nb);
        check("flush_pre_beats", 64'(nb), 64'(10));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_busy", 64'(busy), 64'(0));
        bg_sel       = 1'b0;
        ils_selected = 3'd7;
        j_exp        = 3'd7;
        start        = 1'b1;
        flush        = 1'b1;
        step();
        start        = 1'b0;
        flush        = 1'b0;
        check("start_flush_no_err", 64'(cfg_err), 64'(0));
        check("start_flush_no_busy", 64'(busy), 64'(0));
        do_start(1'b1, 0, 0);
        collect(1'b1, 0, 0, 100, 1000, nb);
        check("restart_beats", 64'(nb), 64'(50));

        // Reset mid-stream
        do_start(1'b1, 5, 2);
        collect(1'b1, 5, 2, 100, 5, nb);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_last", 64'(out_last), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_data", 64'(out_data), 64'(0));
        check("mid_rst_lv", 64'(out_lane_valid), 64'(0));
        check("mid_rst_index", 64'(out_index), 64'(0));
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_rst_idle", 64'({busy, out_valid}), 64'(0));
        end

        // Two streams back to back
        do_start(1'b1, 2, 6);
        collect(1'b1, 2, 6, 100, 1000, nb);
        check("b2b_a_beats", 64'(nb), 64'(50));
        do_start(1'b1, 6, 4);
        check("b2b_b_busy", 64'(busy), 64'(1));
        collect(1'b1, 6, 4, 100, 1000, nb);
        check("b2b_b_beats", 64'(nb), 64'(50));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
